cmd_frame_parser: RTL

Command-frame parser between the byte receiver and the byte transmitter of the serial command interface. It consumes the receiver's `newrxstrobe`/`rxbyte` stream and assembles fixed 6-byte command frames. It executes register reads and writes on a simple internal register bus. It emits reply bytes as single-cycle `xmit`/`txchar` pushes into the transmitter FIFO.

---
 rtl/cmd_frame_parser_if.sv | 24 ++
 rtl/cmd_frame_parser.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cmd_frame_parser_if.sv
// Byte-stream, reply-push and register-bus signals of the command-frame parser.
interface cmd_frame_parser_if;
    logic        newrxstrobe;
    logic [7:0]  rxbyte;
    logic        xmit;
    logic [7:0]  txchar;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;

    // Parser side
    modport master (
        input  newrxstrobe, rxbyte, reg_rdata,
        output xmit, txchar, reg_addr, reg_wdata, reg_we, reg_re
    );

    // Receiver/transmitter/register-file side
    modport slave (
        output newrxstrobe, rxbyte, reg_rdata,
        input  xmit, txchar, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/cmd_frame_parser.sv
// Assembles 6-byte command frames (SYNC CMD ADDR DHI DLO CHK), runs the register
// read/write they request and pushes the ACK/NAK or read-reply bytes.
module cmd_frame_parser #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic                  clk,
    input  logic                  resetn,
    cmd_frame_parser_if.master    bus,
    output logic [7:0]            err_cnt
);
    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] Ack      = 8'h06;
    localparam logic [7:0] Nak      = 8'h15;

    typedef enum logic [3:0] {
        StHunt, StCmd, StAddr, StDhi, StDlo, StChk, StExec, StRdcap, StReply
    } state_e;

    state_e      state;
    logic [7:0]  cmd_b, addr_b, dhi_b, dlo_b;
    logic [15:0] gap_cnt;
    logic [15:0] rdata_cap;
    logic [1:0]  reply_left;

    logic in_frame, timeout, chk_ok, is_wr, is_rd, err_inc;

    // Frame validity, inter-byte timeout and error-event decode
    always_comb begin
        in_frame = (state == StCmd) || (state == StAddr) || (state == StDhi) ||
                   (state == StDlo) || (state == StChk);
        // Gap counter reads k-1 in the k-th cycle after the last strobe, so this
        // fires in cycle T+TIMEOUT-1 and HUNT is back in cycle T+TIMEOUT.
        timeout  = in_frame && !bus.newrxstrobe && (gap_cnt == TIMEOUT - 16'd2);
        chk_ok   = ((cmd_b ^ addr_b ^ dhi_b ^ dlo_b) == bus.rxbyte);
        is_wr    = chk_ok && (cmd_b == CmdWrite);
        is_rd    = chk_ok && (cmd_b == CmdRead);
        // In EXEC, reg_we/reg_re remember which command was accepted.
        err_inc  = timeout ||
                   (bus.newrxstrobe &&
                    ((state == StExec) || (state == StRdcap) || (state == StReply))) ||
                   ((state == StExec) && !bus.reg_we && !bus.reg_re);
    end

    // Frame FSM with registered strobes, reply pushes and error counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= StHunt;
            cmd_b         <= 8'h00;
            addr_b        <= 8'h00;
            dhi_b         <= 8'h00;
            dlo_b         <= 8'h00;
            gap_cnt       <= 16'h0000;
            rdata_cap     <= 16'h0000;
            reply_left    <= 2'd0;
            err_cnt       <= 8'h00;
            bus.xmit      <= 1'b0;
            bus.txchar    <= 8'h00;
            bus.reg_addr  <= 8'h00;
            bus.reg_wdata <= 16'h0000;
            bus.reg_we    <= 1'b0;
            bus.reg_re    <= 1'b0;
        end else begin
            bus.reg_we <= 1'b0;
            bus.reg_re <= 1'b0;
            bus.xmit   <= 1'b0;

            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (in_frame && !bus.newrxstrobe) begin
                gap_cnt <= gap_cnt + 16'd1;
            end else begin
                gap_cnt <= 16'h0000;
            end

            unique case (state)
                StHunt: begin
                    if (bus.newrxstrobe && (bus.rxbyte == SYNC)) state <= StCmd;
                end
                StCmd: begin
                    if (bus.newrxstrobe) begin
                        cmd_b <= bus.rxbyte;
                        state <= StAddr;
                    end
                end
                StAddr: begin
                    if (bus.newrxstrobe) begin
                        addr_b <= bus.rxbyte;
                        state  <= StDhi;
                    end
                end
                StDhi: begin
                    if (bus.newrxstrobe) begin
                        dhi_b <= bus.rxbyte;
                        state <= StDlo;
                    end
                end
                StDlo: begin
                    if (bus.newrxstrobe) begin
                        dlo_b <= bus.rxbyte;
                        state <= StChk;
                    end
                end
                StChk: begin
                    if (bus.newrxstrobe) begin
                        bus.reg_addr  <= addr_b;
                        bus.reg_wdata <= {dhi_b, dlo_b};
                        bus.reg_we    <= is_wr;
                        bus.reg_re    <= is_rd;
                        state         <= StExec;
                    end
                end
                StExec: begin
                    if (bus.reg_re) begin
                        state <= StRdcap;
                    end else begin
                        bus.xmit   <= 1'b1;
                        bus.txchar <= bus.reg_we ? Ack : Nak;
                        reply_left <= 2'd0;
                        state      <= StReply;
                    end
                end
                StRdcap: begin
                    rdata_cap  <= bus.reg_rdata;
                    bus.xmit   <= 1'b1;
                    bus.txchar <= SYNC;
                    reply_left <= 2'd3;
                    state      <= StReply;
                end
                StReply: begin
                    if (reply_left != 2'd0) begin
                        bus.xmit   <= 1'b1;
                        reply_left <= reply_left - 2'd1;
                        case (reply_left)
                            2'd3:    bus.txchar <= rdata_cap[15:8];
                            2'd2:    bus.txchar <= rdata_cap[7:0];
                            default: bus.txchar <= rdata_cap[15:8] ^ rdata_cap[7:0];
                        endcase
                    end else begin
                        state <= StHunt;
                    end
                end
                default: state <= StHunt;
            endcase

            // Only fires without a strobe, so it never collides with a byte advance.
            if (timeout) state <= StHunt;
        end
    end
endmodule
